// File: rtl/lamp_driver.sv
// lamp_driver: three-channel PWM lamp output stage.
//   Takes the luminosity/color codes from light_control and drives R/G/B PWM channels.
//   Brightness ramps one LSB per FADE_DIV cycles; a color change fades to dark, swaps the
//   channel selection while dark, then fades back in.
// Ports:
//   clk          - single clock
//   reset        - asynchronous, active-low reset
//   luminosity   - level code: 00 OFF, 01 LOW, 10 MID, 11 HIGH
//   color        - color code: 00 WHITE, 01 RED, 10 GREEN, 11 BLUE
//   pwm_r/g/b    - registered channel drives
//   duty         - brightness currently applied
//   active_color - color currently driven
//   busy         - high while a ramp or color swap is in progress
module lamp_driver #(
  parameter int unsigned PWM_BITS = 8,
  parameter int unsigned FADE_DIV = 256,
  parameter int unsigned LVL_LOW  = 64,
  parameter int unsigned LVL_MID  = 160,
  parameter int unsigned LVL_HIGH = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          luminosity,
  input  logic [1:0]          color,
  output logic                pwm_r,
  output logic                pwm_g,
  output logic                pwm_b,
  output logic [PWM_BITS-1:0] duty,
  output logic [1:0]          active_color,
  output logic                busy
);

  localparam int unsigned PreW = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam logic [PreW-1:0]     PreLast = PreW'(FADE_DIV - 1);
  localparam logic [PWM_BITS-1:0] DutyMax = '1;
  localparam logic [PWM_BITS-1:0] DutyLow = PWM_BITS'(LVL_LOW);
  localparam logic [PWM_BITS-1:0] DutyMid = PWM_BITS'(LVL_MID);
  localparam logic [PWM_BITS-1:0] DutyHi  = PWM_BITS'(LVL_HIGH);

  typedef enum logic [1:0] {StIdle, StRamp, StDimOut} state_e;

  state_e              state_q, state_d;
  logic [1:0]          lum_q, col_q;
  logic [1:0]          act_q, act_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [PWM_BITS-1:0] cnt_q;
  logic [PreW-1:0]     pre_q, pre_d;
  logic                pwm_r_q, pwm_g_q, pwm_b_q;

  logic [PWM_BITS-1:0] target;
  logic [PWM_BITS-1:0] duty_up, duty_dn;
  logic                tick;
  logic                en_r, en_g, en_b;

  always_comb begin
    unique case (lum_q)
      2'b01:   target = DutyLow;
      2'b10:   target = DutyMid;
      2'b11:   target = DutyHi;
      default: target = '0;
    endcase
  end

  // Saturating one-LSB steps.
  assign duty_up = (duty_q == DutyMax) ? duty_q : duty_q + 1'b1;
  assign duty_dn = (duty_q == '0) ? duty_q : duty_q - 1'b1;

  assign tick = (pre_q == PreLast);

  // Prescaler restarts from zero whenever the FSM sits in IDLE, so the first step of any
  // transition lands exactly FADE_DIV cycles after leaving IDLE.
  always_comb begin
    if (state_q == StIdle || tick) pre_d = '0;
    else                           pre_d = pre_q + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    act_d   = act_q;
    unique case (state_q)
      StIdle: begin
        if (col_q != act_q) begin
          if (duty_q == '0) act_d   = col_q;
          else              state_d = StDimOut;
        end else if (duty_q != target) begin
          state_d = StRamp;
        end
      end
      StRamp: begin
        if (col_q != act_q) begin
          state_d = StDimOut;
        end else if (duty_q == target) begin
          state_d = StIdle;
        end else if (tick) begin
          duty_d = (duty_q < target) ? duty_up : duty_dn;
        end
      end
      StDimOut: begin
        // Swap on the edge where duty reaches zero; col_q always holds the newest request.
        if (duty_q == '0 || (tick && duty_dn == '0)) begin
          duty_d  = '0;
          act_d   = col_q;
          state_d = (target != '0) ? StRamp : StIdle;
        end else if (tick) begin
          duty_d = duty_dn;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    en_r = (act_q == 2'b00) || (act_q == 2'b01);
    en_g = (act_q == 2'b00) || (act_q == 2'b10);
    en_b = (act_q == 2'b00) || (act_q == 2'b11);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      lum_q   <= '0;
      col_q   <= '0;
      act_q   <= '0;
      duty_q  <= '0;
      cnt_q   <= '0;
      pre_q   <= '0;
      pwm_r_q <= 1'b0;
      pwm_g_q <= 1'b0;
      pwm_b_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lum_q   <= luminosity;
      col_q   <= color;
      act_q   <= act_d;
      duty_q  <= duty_d;
      cnt_q   <= cnt_q + 1'b1;
      pre_q   <= pre_d;
      pwm_r_q <= (cnt_q < duty_q) && en_r;
      pwm_g_q <= (cnt_q < duty_q) && en_g;
      pwm_b_q <= (cnt_q < duty_q) && en_b;
    end
  end

  assign pwm_r        = pwm_r_q;
  assign pwm_g        = pwm_g_q;
  assign pwm_b        = pwm_b_q;
  assign duty         = duty_q;
  assign active_color = act_q;
  assign busy         = (state_q != StIdle);

endmodule
